// File: rtl/rs232_txn_ctrl_pkg.sv
// Shared definitions for the RS232 command/response transaction controller.
// Holds state encodings, parameter defaults and the response length limit.
package rs232_txn_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND    = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_RECV    = 3'd3,
      ST_DONE    = 3'd4,
      ST_FAIL    = 3'd5
   } txn_state_t;

   localparam int TIMEOUT_CYCLES_DEFAULT = 100000;
   localparam int MAX_RETRY_DEFAULT      = 3;
   localparam int MAX_RSP_LEN            = 4;
   localparam int TMO_CNT_W              = 27;

   // Lengths above the limit are treated as the limit, never as an error.
   function automatic logic [2:0] clamp_rsp_len(input logic [2:0] len);
      return (len > 3'(MAX_RSP_LEN)) ? 3'(MAX_RSP_LEN) : len;
   endfunction

endpackage

// File: rtl/rs232_txn_ctrl_rx_timeout.sv
// Inter-byte receive timeout: down-counter reloaded on restart or while
// disabled, saturating at zero; expired is the terminal-count compare.
module rs232_rx_timeout
   import rs232_txn_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk_ref,
   input  logic rst_n,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam logic [TMO_CNT_W-1:0] TC_LOAD = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_CNT_W-1:0] cnt;

   // Loaded value means zero cycles elapsed; terminal count is reached
   // TIMEOUT_CYCLES-1 cycles after the last restart or enable.
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= TC_LOAD;
      end else if (restart || !enable) begin
         cnt <= TC_LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - TMO_CNT_W'(1);
      end
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/rs232_txn_ctrl.sv
// RS232 transaction controller: sends one command byte, collects up to four
// response bytes, and re-sends the command on an inter-byte timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a request; rsp_data / retry_cnt hold last result
// ST_SEND    | wait for transmitter idle, then strobe the command byte
// ST_WAIT_TX | wait for the command byte to leave the transmitter
// ST_RECV    | shift in response bytes, watch the inter-byte timeout
// ST_DONE    | one-cycle rsp_valid pulse
// ST_FAIL    | one-cycle rsp_error pulse
module rs232_txn_ctrl
   import rs232_txn_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int MAX_RETRY      = MAX_RETRY_DEFAULT
) (
   input  logic        clk_ref,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_cmd,
   input  logic [2:0]  req_rsp_len,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_valid,
   output logic        rsp_error,
   output logic [1:0]  retry_cnt
);

   localparam logic [1:0] MAX_RETRY_L = 2'(MAX_RETRY);

   txn_state_t state;
   logic [7:0] cmd_q;
   logic [2:0] len_q;
   logic [2:0] byte_cnt;
   logic       tx_first;
   logic       tmo_expired;
   logic       in_recv;

   assign in_recv = (state == ST_RECV);

   rs232_rx_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx_timeout (
      .clk_ref (clk_ref),
      .rst_n   (rst_n),
      .restart (in_recv && rx_valid),
      .enable  (in_recv),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         tx_data   <= 8'h00;
         tx_start  <= 1'b0;
         rsp_data  <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         retry_cnt <= 2'd0;
         cmd_q     <= 8'h00;
         len_q     <= 3'd0;
         byte_cnt  <= 3'd0;
         tx_first  <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  cmd_q     <= req_cmd;
                  len_q     <= clamp_rsp_len(req_rsp_len);
                  rsp_data  <= 32'h0;
                  byte_cnt  <= 3'd0;
                  retry_cnt <= 2'd0;
                  req_ready <= 1'b0;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= cmd_q;
                  tx_first <= 1'b1;
                  state    <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               // tx_busy only rises one cycle after the strobe, so the first
               // cycle here says nothing about the transmitter.
               if (tx_first) begin
                  tx_first <= 1'b0;
               end else if (!tx_busy) begin
                  if (len_q == 3'd0) begin
                     rsp_valid <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     state <= ST_RECV;
                  end
               end
            end
            ST_RECV: begin
               // A byte arriving on the timeout cycle takes priority.
               if (rx_valid) begin
                  rsp_data <= {rsp_data[23:0], rx_data};
                  byte_cnt <= byte_cnt + 3'd1;
                  if (byte_cnt + 3'd1 == len_q) begin
                     rsp_valid <= 1'b1;
                     state     <= ST_DONE;
                  end
               end else if (tmo_expired) begin
                  if (retry_cnt < MAX_RETRY_L) begin
                     retry_cnt <= retry_cnt + 2'd1;
                     rsp_data  <= 32'h0;
                     byte_cnt  <= 3'd0;
                     state     <= ST_SEND;
                  end else begin
                     rsp_error <= 1'b1;
                     state     <= ST_FAIL;
                  end
               end
            end
            ST_DONE, ST_FAIL: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
